spi_result_tx: RTL and testbench
================================

Name: spi_result_tx

Overview:
SPI-style serial transmitter for AES results, the outbound counterpart to the inbound key/data shifters. A 128-bit encrypted or decrypted block is loaded from the cipher core into a holding register. It is shifted out MSB-first on miso, one bit per clk, while the host holds cs low. A holding register plus a shift register give double buffering, so the core can post the next result while the current one is still shifting out.

Parameters:
DATASIZE, 128, width of one result word in bits.

Ports:
- clk  input  1  system clock; also the bit clock, one bit per rising edge.
- rst  input  1  synchronous, active-low reset.
- load  input  1  single-cycle strobe; accept data_in into the holding register.
- data_in  input  DATASIZE  result word from the cipher core.
- ready  output  1  holding register empty; a load will be accepted.
- cs  input  1  active-low frame select from the host.
- miso  output  1  registered serial data out.
- busy  output  1  high in SHIFT state.
- done  output  1  one-cycle pulse when a frame completes.
- err  output  1  one-cycle pulse on an aborted frame or an underrun.

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE; the holding and shift registers clear; hold_valid=0.
  - Outputs: miso=0, busy=0, done=0, err=0, ready=1.
  - Reset mid-frame discards all data.
- ready is the inverse of hold_valid (combinational).
- Load rules:
  - load with ready=1: hold <= data_in, hold_valid <= 1.
  - load with ready=0: ignored; hold is unchanged and no flag is raised.
  - Load is accepted in any state.
- State machine, states IDLE, SHIFT, WAIT_RELEASE:
  - IDLE, cs==0, hold_valid==1 (edge E0): shift <= hold, hold_valid <= 0, bit counter <= 0, go to SHIFT. After E0, miso = data bit DATASIZE-1 and busy=1.
  - IDLE, cs==0, hold_valid==0: underrun. err pulses for one cycle, miso stays 0, go to WAIT_RELEASE.
  - IDLE, cs==1: stay in IDLE.
  - SHIFT, cs==0: at each edge Ek (k=1..DATASIZE-1), shift left and increment the counter. After Ek, miso = bit DATASIZE-1-k.
  - SHIFT, end of frame: at edge E(DATASIZE) the last bit has been presented for exactly one cycle. Go to WAIT_RELEASE; done=1 for one cycle; miso=0; busy=0.
  - SHIFT, cs==1 before the frame completes: abort. err pulses for one cycle, the word is discarded (not restored to hold), go to IDLE, miso=0.
  - WAIT_RELEASE: stay while cs==0 with miso=0. Go to IDLE on the first edge that samples cs==1. This guarantees one frame per cs assertion.
- Simultaneous events:
  - A load in the same cycle as the IDLE-to-SHIFT transfer is ignored, because ready was 0.
  - A load during SHIFT is accepted without disturbing the shift register.
  - A load in the same cycle as an abort is accepted.
- Counter width is $clog2(DATASIZE+8)+1 bits. There is no wrap-around; the counter is only compared for equality with the frame length.
- done and err are never high in the same cycle.

Optional Feature:
SPI_TX_CRC8_EN
- Defined:
  - After the DATASIZE data bits, 8 CRC bits are appended MSB-first. The CRC is CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR, computed over the data bits in transmit order.
  - Frame length is DATASIZE+8; done pulses at edge E(DATASIZE+8).
  - An abort during the CRC bits behaves exactly as an abort during data.
- Undefined: frame length is DATASIZE and the CRC logic is absent.

Test Plan:
- Reset, then load data_in=128'h00112233445566778899AABBCCDDEEFF and drive cs=0 for 130 cycles -> miso reproduces the word MSB-first starting the cycle after cs is sampled low; done pulses once after bit 0; ready=1 from the E0 transfer onward.
- Load word A, start the frame, load word B at bit 40, release cs after done, then assert cs again -> the first frame sends A and the second sends B intact; busy is high only during shifting.
- cs=0 with no load -> err pulses once, miso stays 0 for the whole assertion, no done; after cs goes high the block returns to IDLE.
- Start a frame, raise cs after 50 bits -> err pulses for one cycle, no done, ready=1, and the next cs assertion gives an underrun.
- Hold rst=0 at bit 70 for one edge -> the next cycle shows miso=0, busy=0, ready=1, and the old data is never emitted.
- With DATASIZE=8 and SPI_TX_CRC8_EN defined, load 8'h01 and cs=0 -> miso sends 00000001 then 00000111 (CRC 0x07); done pulses after bit 16.

Source files
------------

// File: rtl/spi_result_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_result_tx_if
// Purpose  : Bundles the result-transmitter load handshake and the SPI-side
//            frame signals between the cipher core/host and spi_result_tx.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_result_tx_if #(
  parameter int DATASIZE = 128
) ();
  logic                load;
  logic [DATASIZE-1:0] data_in;
  logic                ready;
  logic                cs;
  logic                miso;
  logic                busy;
  logic                done;
  logic                err;

  // Transmitter side
  modport slave (
    input  load, data_in, cs,
    output ready, miso, busy, done, err
  );

  // Core/host side
  modport master (
    output load, data_in, cs,
    input  ready, miso, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/spi_result_tx.sv
`default_nettype none
// ============================================================================
// Module   : spi_result_tx
// Purpose  : Double-buffered SPI-style serial transmitter for 128-bit AES
//            results. A holding register accepts the next word while the
//            shift path sends the current one MSB-first on miso, one bit per
//            clk, for each low period of cs.
// Options  : SPI_TX_CRC8_EN - append CRC-8 (poly 0x07, init 0x00) after the
//            data bits, MSB-first.
// Revision : 1.0 - initial release
// ============================================================================
module spi_result_tx #(
  parameter int DATASIZE = 128
) (
  input  logic           clk,
  input  logic           rst,
  spi_result_tx_if.slave bus
);

`ifdef SPI_TX_CRC8_EN
  localparam int FRAME_LEN = DATASIZE + 8;
`else
  localparam int FRAME_LEN = DATASIZE;
`endif
  localparam int               CNT_W    = $clog2(DATASIZE + 8) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] SHIFT        = 2'd1;
  localparam logic [1:0] WAIT_RELEASE = 2'd2;

  logic [1:0]          state;
  logic [DATASIZE-1:0] hold;
  logic                hold_valid;
  // The MSB leaves straight into miso_q at frame start, so only the
  // remaining DATASIZE-1 bits need to be kept for shifting.
  logic [DATASIZE-2:0] shreg;
  logic [CNT_W-1:0]    cnt;
  logic                miso_q;
  logic                done_q;
  logic                err_q;
  logic                start;
  logic                last;
  logic                next_bit;

  assign start = (state == IDLE) && !bus.cs && hold_valid;
  assign last  = (cnt == LAST_CNT);

`ifdef SPI_TX_CRC8_EN
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATASIZE - 1);

  logic [7:0] crc;
  logic [7:0] crc_next;
  logic       in_data;

  // miso_q holds the data bit currently on the wire; fold it into the CRC.
  assign in_data  = (cnt <= DATA_LAST);
  assign crc_next = {crc[6:0], 1'b0} ^ ((crc[7] ^ miso_q) ? 8'h07 : 8'h00);

  // Pick the bit for the next cycle: data, then the finished CRC MSB-first.
  always_comb begin
    next_bit = shreg[DATASIZE-2];
    if (cnt == DATA_LAST) begin
      next_bit = crc_next[7];
    end else if (cnt > DATA_LAST) begin
      next_bit = crc[6];
    end
  end

  // Accumulate CRC over data bits, then shift it out behind them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      crc <= 8'h00;
    end else if (start) begin
      crc <= 8'h00;
    end else if ((state == SHIFT) && !bus.cs && !last) begin
      crc <= in_data ? crc_next : {crc[6:0], 1'b0};
    end
  end
`else
  assign next_bit = shreg[DATASIZE-2];
`endif

  // Holding register: accept a load whenever empty; emptied by frame start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else if (start) begin
      hold_valid <= 1'b0;
    end else if (bus.load && !hold_valid) begin
      hold       <= bus.data_in;
      hold_valid <= 1'b1;
    end
  end

  // Frame state machine, shift path and registered status pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      miso_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          miso_q <= 1'b0;
          if (!bus.cs) begin
            if (hold_valid) begin
              shreg  <= hold[DATASIZE-2:0];
              miso_q <= hold[DATASIZE-1];
              cnt    <= '0;
              state  <= SHIFT;
            end else begin
              // Host selected us with nothing to send: underrun.
              err_q <= 1'b1;
              state <= WAIT_RELEASE;
            end
          end
        end
        SHIFT: begin
          if (bus.cs) begin
            // Aborted frame: the word is dropped, not returned to hold.
            err_q  <= 1'b1;
            miso_q <= 1'b0;
            shreg  <= '0;
            state  <= IDLE;
          end else if (last) begin
            done_q <= 1'b1;
            miso_q <= 1'b0;
            state  <= WAIT_RELEASE;
          end else begin
            shreg  <= {shreg[DATASIZE-3:0], 1'b0};
            miso_q <= next_bit;
            cnt    <= cnt + 1'b1;
          end
        end
        WAIT_RELEASE: begin
          // One frame per cs assertion: wait for the host to deselect.
          miso_q <= 1'b0;
          if (bus.cs) begin
            state <= IDLE;
          end
        end
        default: begin
          miso_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = !hold_valid;
  assign bus.miso  = miso_q;
  assign bus.busy  = (state == SHIFT);
  assign bus.done  = done_q;
  assign bus.err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_result_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_result_tx
// Purpose  : Self-checking bench for spi_result_tx. Frames are predicted from
//            a scoreboard of accepted words and the expected bit sequence
//            (data MSB-first, plus CRC-8 when SPI_TX_CRC8_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_result_tx;
  localparam int DW = 128;
`ifdef SPI_TX_CRC8_EN
  localparam int FL = DW + 8;
`else
  localparam int FL = DW;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          cs = 1'b1;
  logic          ready, miso, busy, done, err;

  int errors = 0;
  int checks = 0;

  // Scoreboard of the holding register as the bench understands it.
  bit            hv = 1'b0;
  logic [DW-1:0] hold_m = '0;

  spi_result_tx_if #(.DATASIZE(DW)) bus ();

  assign bus.load    = load;
  assign bus.data_in = data_in;
  assign bus.cs      = cs;
  assign ready       = bus.ready;
  assign miso        = bus.miso;
  assign busy        = bus.busy;
  assign done        = bus.done;
  assign err         = bus.err;

  spi_result_tx #(.DATASIZE(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock generation
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".miso"}, miso, 1'b0);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".done"}, done, 1'b0);
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW; i++) w[i] = 1'($urandom_range(0, 1));
    return w;
  endfunction

  task automatic do_load(input logic [DW-1:0] w);
    bit take;
    load    = 1'b1;
    data_in = w;
    take    = !hv;
    tick();
    load = 1'b0;
    if (take) begin
      hv     = 1'b1;
      hold_m = w;
    end
    chk("load.ready", ready, !hv);
  endtask

  task automatic underrun();
    cs = 1'b0;
    tick();
    chk("urun.err", err, 1'b1);
    chk_quiet("urun");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("urun.err_hold", err, 1'b0);
      chk_quiet("urun_hold");
    end
    cs = 1'b1;
    tick();
    chk_quiet("urun_rel");
    chk("urun_rel.err", err, 1'b0);
  endtask

  // Runs one cs assertion on the word currently held. Optionally aborts,
  // loads a new word, or pulses reset after bit k has been presented.
  task automatic run_frame(input int abort_k, input int load_k,
                           input logic [DW-1:0] wb, input int rst_k);
    logic [DW-1:0] w;
    bit            bits[FL];
    logic [7:0]    c;
    bit            fb;
    bit            take;
    w = hold_m;
    c = 8'h00;
    for (int i = 0; i < DW; i++) begin
      bits[i] = w[DW-1-i];
      fb = c[7] ^ w[DW-1-i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    for (int j = DW; j < FL; j++) bits[j] = c[7-(j-DW)];

    cs = 1'b0;
    tick();           // E0: hold -> shift
    load = 1'b0;
    hv   = 1'b0;
    for (int k = 0; k < FL; k++) begin
      chk("frm.miso", miso, bits[k]);
      chk("frm.busy", busy, 1'b1);
      chk("frm.done", done, 1'b0);
      chk("frm.err", err, 1'b0);
      chk("frm.ready", ready, !hv);
      load = 1'b0;
      if (k == load_k) begin
        load    = 1'b1;
        data_in = wb;
      end
      if (k == rst_k) begin
        rst = 1'b0;
        cs  = 1'b1;
        tick();
        rst = 1'b1;
        hv  = 1'b0;
        chk_quiet("rst");
        chk("rst.ready", ready, 1'b1);
        chk("rst.err", err, 1'b0);
        for (int i = 0; i < 3; i++) begin
          tick();
          chk_quiet("rst_after");
          chk("rst_after.err", err, 1'b0);
        end
        return;
      end
      if (k == abort_k) cs = 1'b1;
      take = load && !hv;
      tick();
      if (take) begin
        hv     = 1'b1;
        hold_m = data_in;
      end
      if (k == abort_k) begin
        load = 1'b0;
        chk("abort.err", err, 1'b1);
        chk_quiet("abort");
        chk("abort.ready", ready, !hv);
        tick();
        chk("abort.err_after", err, 1'b0);
        chk_quiet("abort_after");
        return;
      end
    end
    load = 1'b0;
    chk("end.done", done, 1'b1);
    chk("end.err", err, 1'b0);
    chk("end.busy", busy, 1'b0);
    chk("end.miso", miso, 1'b0);
    chk("end.ready", ready, !hv);
    tick();
    chk_quiet("wait");
    chk("wait.err", err, 1'b0);
    tick();
    chk_quiet("wait2");
    cs = 1'b1;
    tick();
    chk_quiet("release");
    chk("release.err", err, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] wa;
    logic [DW-1:0] wb;
    int            ab;

    // Reset state
    tick();
    tick();
    chk_quiet("reset");
    chk("reset.err", err, 1'b0);
    chk("reset.ready", ready, 1'b1);
    rst = 1'b1;
    tick();

    // Known word, full frame
    do_load(DW'(128'h00112233445566778899AABBCCDDEEFF));
    run_frame(-1, -1, '0, -1);

    // Double buffering: load B at bit 40 of A's frame, then send B
    wa = rand_word();
    wb = rand_word();
    do_load(wa);
    run_frame(-1, 40, wb, -1);
    run_frame(-1, -1, '0, -1);

    // Underrun with nothing held
    underrun();

    // Load while full is ignored; load in transfer cycle ignored; abort at 50
    do_load(rand_word());
    do_load(rand_word());
    load    = 1'b1;
    data_in = rand_word();
    run_frame(50, -1, '0, -1);
    underrun();

    // Reset mid-frame at bit 70
    do_load(rand_word());
    run_frame(-1, -1, '0, 70);
    underrun();

    // Load accepted on the abort edge, then sent intact
    do_load(rand_word());
    run_frame(20, 20, rand_word(), -1);
    run_frame(-1, -1, '0, -1);

    // Randomized frames, some aborted
    for (int n = 0; n < 4; n++) begin
      do_load(rand_word());
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, FL - 2)) : -1;
      run_frame(ab, -1, '0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
